// File: rtl/fxp_expander_pkg.sv
// Shared constants and helpers for the fixed-point expander and its
// counterpart, the output requantizer.
// Default fixed-point formats: Q1.15 in, Q5.45 out.
package fxp_expander_pkg;

    localparam int DEF_NB_DATA_IN   = 16;
    localparam int DEF_NBF_DATA_IN  = 15;
    localparam int DEF_NB_DATA_OUT  = 50;
    localparam int DEF_NBF_DATA_OUT = 45;
    localparam int DEF_NB_SHIFT     = 3;
    localparam int DEF_NB_CNT       = 16;

    // Integer bit counts and the alignment distance for the default formats.
    localparam int NBI_DATA_IN  = DEF_NB_DATA_IN - DEF_NBF_DATA_IN;
    localparam int NBI_DATA_OUT = DEF_NB_DATA_OUT - DEF_NBF_DATA_OUT;
    localparam int ALIGN_SHIFT  = DEF_NBF_DATA_OUT - DEF_NBF_DATA_IN;

    // Widest format the saturation constant helpers can describe.
    localparam int NB_MAX = 128;

    // Distance the input binary point moves to line up with the output one.
    function automatic int align_shift(input int nbf_out, input int nbf_in);
        return nbf_out - nbf_in;
    endfunction

    // Width of the shifted result: wide enough that no gain shift loses
    // the sign, so overflow can be judged from the extra top bits.
    function automatic int ext_width(input int nb_out, input int nb_shift);
        return nb_out + (2 ** nb_shift);
    endfunction

    // Most negative nb-bit two's complement value {1,0...0}, zero-extended.
    function automatic logic [NB_MAX-1:0] max_neg(input int nb);
        return {{(NB_MAX-1){1'b0}}, 1'b1} << (nb - 1);
    endfunction

    // Most positive nb-bit two's complement value {0,1...1}, zero-extended.
    function automatic logic [NB_MAX-1:0] max_pos(input int nb);
        return max_neg(nb) - {{(NB_MAX-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fxp_align_sat.sv
// Combinational align, power-of-two gain, overflow detect and
// saturate/wrap. Saturation is selected by defining FXP_EXP_SAT_EN;
// otherwise overflowed samples wrap to the low output bits.
module fxp_align_sat
    import fxp_expander_pkg::*;
#(
    parameter int NB_DATA_IN   = DEF_NB_DATA_IN,
    parameter int NBF_DATA_IN  = DEF_NBF_DATA_IN,
    parameter int NB_DATA_OUT  = DEF_NB_DATA_OUT,
    parameter int NBF_DATA_OUT = DEF_NBF_DATA_OUT,
    parameter int NB_SHIFT     = DEF_NB_SHIFT
) (
    input  logic [NB_DATA_IN-1:0]  data,
    input  logic [NB_SHIFT-1:0]    shift,
    output logic [NB_DATA_OUT-1:0] result,
    output logic                   ovf
);

    localparam int ALIGN = align_shift(NBF_DATA_OUT, NBF_DATA_IN);
    localparam int EXT_W = ext_width(NB_DATA_OUT, NB_SHIFT);

    localparam logic [NB_MAX-1:0] MAX_POS_W = max_pos(NB_DATA_OUT);
    localparam logic [NB_MAX-1:0] MAX_NEG_W = max_neg(NB_DATA_OUT);
    localparam logic [NB_DATA_OUT-1:0] MAX_POS_V = MAX_POS_W[NB_DATA_OUT-1:0];
    localparam logic [NB_DATA_OUT-1:0] MAX_NEG_V = MAX_NEG_W[NB_DATA_OUT-1:0];

    logic [EXT_W-1:0]           ext_s;
    logic [EXT_W-1:0]           aligned_s;
    logic [EXT_W-1:0]           shifted_s;
    logic [EXT_W-NB_DATA_OUT:0] top_s;

    // Sign-extend, align binary points, apply gain, then judge overflow by
    // whether every bit from the output sign upward agrees.
    always_comb begin
        ext_s     = {{(EXT_W-NB_DATA_IN){data[NB_DATA_IN-1]}}, data};
        aligned_s = ext_s << ALIGN;
        shifted_s = aligned_s << shift;
        top_s     = shifted_s[EXT_W-1:NB_DATA_OUT-1];
        ovf       = ~((&top_s) | ~(|top_s));
        if (ovf) begin
`ifdef FXP_EXP_SAT_EN
            result = data[NB_DATA_IN-1] ? MAX_NEG_V : MAX_POS_V;
`else
            result = shifted_s[NB_DATA_OUT-1:0];
`endif
        end else begin
            result = shifted_s[NB_DATA_OUT-1:0];
        end
    end

endmodule

// File: rtl/fxp_expander.sv
// Two-stage valid/ready expander from narrow input format to the wide
// accumulator format, with per-sample power-of-two gain and a saturating
// overflow counter. Define FXP_EXP_SAT_EN to saturate overflowed samples
// instead of wrapping them.
module fxp_expander
    import fxp_expander_pkg::*;
#(
    parameter int NB_DATA_IN   = DEF_NB_DATA_IN,
    parameter int NBF_DATA_IN  = DEF_NBF_DATA_IN,
    parameter int NB_DATA_OUT  = DEF_NB_DATA_OUT,
    parameter int NBF_DATA_OUT = DEF_NBF_DATA_OUT,
    parameter int NB_SHIFT     = DEF_NB_SHIFT,
    parameter int NB_CNT       = DEF_NB_CNT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NB_DATA_IN-1:0]  i_data,
    input  logic [NB_SHIFT-1:0]    i_shift,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [NB_DATA_OUT-1:0] o_data,
    output logic                   o_ovf_flag,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic                   i_cnt_clr,
    output logic [NB_CNT-1:0]      o_ovf_count
);

    localparam logic [NB_CNT-1:0] CNT_MAX = {NB_CNT{1'b1}};

    logic                   live_r;
    logic                   s1_v_r;
    logic [NB_DATA_IN-1:0]  s1_data_r;
    logic [NB_SHIFT-1:0]    s1_shift_r;
    logic [NB_DATA_OUT-1:0] calc_data_s;
    logic                   calc_ovf_s;
    logic                   adv2_s;
    logic                   in_xfer_s;
    logic                   load2_s;

    // Handshake: S2 can take a new sample when empty or being drained;
    // S1 can take one when empty or moving forward. o_ready stays low
    // until the first clock after reset has been released.
    always_comb begin
        adv2_s    = ~o_valid | i_ready;
        o_ready   = live_r & (~s1_v_r | adv2_s);
        in_xfer_s = i_valid & o_ready;
        load2_s   = s1_v_r & adv2_s;
    end

    fxp_align_sat #(
        .NB_DATA_IN   (NB_DATA_IN),
        .NBF_DATA_IN  (NBF_DATA_IN),
        .NB_DATA_OUT  (NB_DATA_OUT),
        .NBF_DATA_OUT (NBF_DATA_OUT),
        .NB_SHIFT     (NB_SHIFT)
    ) u_align_sat (
        .data   (s1_data_r),
        .shift  (s1_shift_r),
        .result (calc_data_s),
        .ovf    (calc_ovf_s)
    );

    // Marks the block as out of reset so it can start accepting samples.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            live_r <= 1'b0;
        end else begin
            live_r <= 1'b1;
        end
    end

    // Stage 1: captures the raw sample and its gain on an input transfer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_v_r     <= 1'b0;
            s1_data_r  <= {NB_DATA_IN{1'b0}};
            s1_shift_r <= {NB_SHIFT{1'b0}};
        end else if (in_xfer_s) begin
            s1_v_r     <= 1'b1;
            s1_data_r  <= i_data;
            s1_shift_r <= i_shift;
        end else if (load2_s) begin
            s1_v_r     <= 1'b0;
        end
    end

    // Stage 2: registers the expanded result; held while downstream stalls.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid    <= 1'b0;
            o_data     <= {NB_DATA_OUT{1'b0}};
            o_ovf_flag <= 1'b0;
        end else if (adv2_s) begin
            o_valid <= s1_v_r;
            if (s1_v_r) begin
                o_data     <= calc_data_s;
                o_ovf_flag <= calc_ovf_s;
            end
        end
    end

    // Counts overflowed samples as they enter stage 2; clear has priority
    // and the count sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ovf_count <= {NB_CNT{1'b0}};
        end else if (i_cnt_clr) begin
            o_ovf_count <= {NB_CNT{1'b0}};
        end else if (load2_s && calc_ovf_s && (o_ovf_count != CNT_MAX)) begin
            o_ovf_count <= o_ovf_count + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_fxp_expander.sv
// Self-checking bench for fxp_expander (default Q1.15 -> Q5.45, 3-bit gain).
// Expected outputs come from an arithmetic model: value * 2^(30+shift)
// compared against the Q5.45 range.
module tb_fxp_expander;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_data;
    logic [2:0]  i_shift;
    logic        i_valid;
    logic        o_ready;
    logic [49:0] o_data;
    logic        o_ovf_flag;
    logic        o_valid;
    logic        i_ready;
    logic        i_cnt_clr;
    logic [15:0] o_ovf_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [49:0] d;
        logic        f;
    } exp_t;

    exp_t q[$];

    fxp_expander dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_data      (i_data),
        .i_shift     (i_shift),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_data      (o_data),
        .o_ovf_flag  (o_ovf_flag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .i_cnt_clr   (i_cnt_clr),
        .o_ovf_count (o_ovf_count)
    );

    always #5 i_clk = ~i_clk;

    function automatic exp_t model(input logic [15:0] d, input logic [2:0] sh);
        longint     v;
        longint     lim;
        logic [63:0] vb;
        exp_t       e;
        v   = longint'($signed(d));
        v   = v * (longint'(1) <<< (30 + int'(sh)));
        lim = longint'(1) <<< 49;
        e.f = (v >= lim) || (v < -lim);
        vb  = v;
        e.d = vb[49:0];
`ifdef FXP_EXP_SAT_EN
        if (e.f) e.d = d[15] ? {1'b1, {49{1'b0}}} : {1'b0, {49{1'b1}}};
`endif
        return e;
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_cnt();
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_cnt_clr = 1'b0;
        i_data = 16'h0000; i_shift = 3'd0;
        repeat (2) @(posedge i_clk);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
        total++; if (o_data !== 50'h0) begin bad++; $display("FAIL rst_data got=%h want=0", o_data); end
        total++; if (o_ovf_flag !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b want=0", o_ovf_flag); end
        total++; if (o_ovf_count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h want=0", o_ovf_count); end
        i_reset = 1'b0;
        step();
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", o_ready); end
    endtask

    task automatic test_vectors();
        logic [15:0] vd [6];
        logic [2:0]  vs [6];
        logic [49:0] ve [6];
        logic        vf [6];
        vd[0] = 16'h4000; vs[0] = 3'd0; ve[0] = 50'h0_1000_0000_0000; vf[0] = 1'b0;
        vd[1] = 16'h7FFF; vs[1] = 3'd4; ve[1] = 50'h1_FFFC_0000_0000; vf[1] = 1'b0;
        vd[2] = 16'h8000; vs[2] = 3'd4; ve[2] = 50'h2_0000_0000_0000; vf[2] = 1'b0;
        vd[3] = 16'hFFFF; vs[3] = 3'd0; ve[3] = 50'h3_FFFF_C000_0000; vf[3] = 1'b0;
`ifdef FXP_EXP_SAT_EN
        vd[4] = 16'h4000; vs[4] = 3'd5; ve[4] = 50'h1_FFFF_FFFF_FFFF; vf[4] = 1'b1;
        vd[5] = 16'h8000; vs[5] = 3'd5; ve[5] = 50'h2_0000_0000_0000; vf[5] = 1'b1;
`else
        vd[4] = 16'h4000; vs[4] = 3'd5; ve[4] = 50'h2_0000_0000_0000; vf[4] = 1'b1;
        vd[5] = 16'h8000; vs[5] = 3'd5; ve[5] = 50'h0_0000_0000_0000; vf[5] = 1'b1;
`endif
        clr_cnt();
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_data = vd[k]; i_shift = vs[k]; i_valid = 1'b1;
            step();
            i_valid = 1'b0;
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_early got=%b want=0", k, o_valid); end
            step();
            total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL vec%0d_valid got=%b want=1", k, o_valid); end
            total++; if (o_data !== ve[k]) begin bad++; $display("FAIL vec%0d_data got=%h want=%h", k, o_data, ve[k]); end
            total++; if (o_ovf_flag !== vf[k]) begin bad++; $display("FAIL vec%0d_flag got=%b want=%b", k, o_ovf_flag, vf[k]); end
            step();
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL vec%0d_drop got=%b want=0", k, o_valid); end
        end
        total++; if (o_ovf_count !== 16'd2) begin bad++; $display("FAIL vec_count got=%0d want=2", o_ovf_count); end
    endtask

    task automatic test_random_stream();
        exp_t e;
        int   exp_cnt = 0;
        logic exp_rdy;
        clr_cnt();
        q.delete();
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_data  = 16'($urandom);
            i_shift = 3'($urandom);
            #1;
            exp_rdy = !(q.size() == 2 && !i_ready);
            total++; if (o_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, o_ready, exp_rdy); end
            if (o_valid && i_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_extra c=%0d got=%h want=none", c, o_data);
                end else begin
                    e = q.pop_front();
                    if (o_data !== e.d || o_ovf_flag !== e.f) begin
                        bad++; $display("FAIL rnd_out c=%0d got=%h/%b want=%h/%b", c, o_data, o_ovf_flag, e.d, e.f);
                    end
                end
            end
            if (i_valid && o_ready) begin
                e = model(i_data, i_shift);
                q.push_back(e);
                if (e.f) exp_cnt++;
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0; i_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (o_valid && q.size() != 0) begin
                e = q.pop_front();
                total++;
                if (o_data !== e.d || o_ovf_flag !== e.f) begin
                    bad++; $display("FAIL rnd_drain got=%h/%b want=%h/%b", o_data, o_ovf_flag, e.d, e.f);
                end
            end
            step();
        end
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d want=0 pending", q.size()); end
        total++; if (o_ovf_count !== 16'(exp_cnt)) begin bad++; $display("FAIL rnd_count got=%0d want=%0d", o_ovf_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          accepted = 0;
        int          emitted  = 0;
        logic        pat [4];
        logic        hold = 1'b0;
        logic [49:0] held;
        logic        exp_rdy;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        q.delete();
        for (int c = 0; c < 60 && emitted < 8; c++) begin
            i_valid = (accepted < 8);
            i_ready = pat[c % 4];
            i_data  = 16'($urandom);
            i_shift = 3'($urandom_range(0, 4));
            #1;
            if (hold) begin
                total++;
                if (o_valid !== 1'b1 || o_data !== held) begin
                    bad++; $display("FAIL bp_stable c=%0d got=%h want=%h", c, o_data, held);
                end
            end
            exp_rdy = !(q.size() == 2 && !i_ready);
            total++; if (o_ready !== exp_rdy) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, o_ready, exp_rdy); end
            if (o_valid && i_ready && q.size() != 0) begin
                e = q.pop_front();
                emitted++;
                total++;
                if (o_data !== e.d) begin bad++; $display("FAIL bp_out c=%0d got=%h want=%h", c, o_data, e.d); end
            end
            if (i_valid && o_ready) begin
                q.push_back(model(i_data, i_shift));
                accepted++;
            end
            hold = o_valid && !i_ready;
            held = o_data;
            @(posedge i_clk);
            #1;
        end
        total++; if (emitted != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", emitted); end
        i_valid = 1'b0; i_ready = 1'b1;
        step(); step();
    endtask

    task automatic test_counter();
        clr_cnt();
        i_ready = 1'b1; i_valid = 1'b1; i_data = 16'h4000; i_shift = 3'd5;
        repeat (65536 + 3) step();
        i_valid = 1'b0;
        repeat (4) step();
        total++; if (o_ovf_count !== 16'hFFFF) begin bad++; $display("FAIL cnt_sat got=%h want=ffff", o_ovf_count); end
        i_valid = 1'b1; i_data = 16'h8000; i_shift = 3'd7;
        step();
        i_valid = 1'b0; i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        total++; if (o_ovf_flag !== 1'b1 || o_valid !== 1'b1) begin bad++; $display("FAIL clr_load got=%b/%b want=1/1", o_valid, o_ovf_flag); end
        total++; if (o_ovf_count !== 16'h0) begin bad++; $display("FAIL clr_win got=%h want=0", o_ovf_count); end
        step();
        total++; if (o_ovf_count !== 16'h0) begin bad++; $display("FAIL clr_hold got=%h want=0", o_ovf_count); end
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b1; i_valid = 1'b1; i_shift = 3'd6; i_data = 16'h7000;
        repeat (3) step();
        i_reset = 1'b1;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", o_valid); end
        total++; if (o_ovf_count !== 16'h0) begin bad++; $display("FAIL mid_count got=%h want=0", o_ovf_count); end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        step(); step();
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_emit got=%b want=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", o_ready); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random_stream();
        test_back_to_back();
        test_counter();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
